// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//   Datapath of the shift-and-add multiplier. The control FSM drives the
//   load/ad/sh strobes; this block returns m (current multiplier LSB) and k
//   (last-bit flag).
//   It holds a (2N+1)-bit accumulator/multiplier register ACC, the multiplicand
//   register MC and a bit counter, and exposes the 2N-bit product.
//
//   Handshake: there is no valid/ready pair. Strobes act on the posedge where
//   they are high. The priority order is rst > load > {ad, sh}. When ad and sh
//   are both high, the add happens first and then the sum is shifted.
//
//   Optional macro PROD_REG_EN:
//     undefined - product is ACC[2N-1:0] (combinational) and prod_valid is 0.
//     defined   - product is a register. It loads on the final shift
//                 (sh=1 and k=1), and prod_valid pulses for one cycle after
//                 that load.
// -----------------------------------------------------------------------------
module mult_datapath #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ad,
    input  logic             sh,
    input  logic [N-1:0]     mcand,
    input  logic [N-1:0]     mplier,
    output logic             m,
    output logic             k,
    output logic [2*N-1:0]   product,
    output logic             prod_valid
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [2*N:0]   acc;
    logic [2*N:0]   acc_next;
    logic [N-1:0]   mc;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [N:0]     sum;

    // Upper half plus multiplicand. The (N+1)-bit result keeps the carry,
    // which becomes ACC[2N].
    assign sum = {1'b0, acc[2*N-1:N]} + {1'b0, mc};

    // Next accumulator and counter values. load wins over ad/sh; with no
    // strobe active, everything holds.
    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (load) begin
            acc_next = {{(N+1){1'b0}}, mplier};
            cnt_next = '0;
        end else begin
            case ({ad, sh})
                2'b10:   acc_next = {sum, acc[N-1:0]};
                2'b01:   acc_next = {1'b0, acc[2*N:1]};
                2'b11:   acc_next = {1'b0, sum, acc[N-1:1]};
                default: acc_next = acc;
            endcase
            if (sh) begin
                cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end
        end
    end

    // Accumulator, multiplicand and counter registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            mc  <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (load) begin
                mc <= mcand;
            end
        end
    end

    // Status bits the control FSM uses to decide add and when to stop.
    assign m = acc[0];
    assign k = (cnt == CNT_LAST);

`ifdef PROD_REG_EN
    logic [2*N-1:0] prod_q;
    logic           pv_q;
    logic           capture;

    // The final shift of an operation. A simultaneous load cancels the shift.
    assign capture = sh & k & ~load;

    // Product register: takes the post-shift ACC on the final shift, and holds
    // across loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            pv_q <= capture;
            if (capture) begin
                prod_q <= acc_next[2*N-1:0];
            end
        end
    end

    assign product    = prod_q;
    assign prod_valid = pv_q;
`else
    assign product    = acc[2*N-1:0];
    assign prod_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
//   Directed test of mult_datapath with N=4.
//   An arithmetic model tracks ACC as an integer:
//     - an add adds MC * 2^N to the lower 2N bits,
//     - a shift divides by 2,
//     - the counter counts modulo N.
//   A compare process checks every output against this model on each negedge.
//   Literal checks fix the end results and the status flags.
//   Build with +define+PROD_REG_EN to exercise the registered-product variant.
// -----------------------------------------------------------------------------
module tb_mult_datapath;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0, ad = 1'b0, sh = 1'b0;
  logic [N-1:0] mcand = '0, mplier = '0;
  logic m, k, prod_valid;
  logic [2*N-1:0] product;

  always #5 clk = ~clk;

  mult_datapath #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .ad(ad), .sh(sh),
    .mcand(mcand), .mplier(mplier),
    .m(m), .k(k), .product(product), .prod_valid(prod_valid)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int acc_m = 0;
  int mc_m = 0;
  int cnt_m = 0;
  int prod_m = 0;
  bit pv_m = 1'b0;
  localparam int MOD2N = 1 << (2 * N);

  // Update the model on each clock edge from the strobes being driven.
  always @(posedge clk) begin
    if (rst) begin
      acc_m = 0; mc_m = 0; cnt_m = 0; prod_m = 0; pv_m = 1'b0;
    end else if (load) begin
      acc_m = int'(mplier); mc_m = int'(mcand); cnt_m = 0; pv_m = 1'b0;
    end else begin
      bit fire;
      fire = sh && (cnt_m == N - 1);
      if (ad) acc_m = (acc_m % MOD2N) + (mc_m << N);
      if (sh) begin
        acc_m = acc_m >> 1;
        cnt_m = (cnt_m + 1) % N;
      end
      if (fire) prod_m = acc_m % MOD2N;
      pv_m = fire;
    end
  end

  // ---------------- scoreboard compare ----------------
  // Compare every output against the model on every negedge after reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m", m, acc_m & 1);
      check("k", k, (cnt_m == N - 1) ? 1 : 0);
`ifdef PROD_REG_EN
      check("product", product, prod_m);
      check("prod_valid", prod_valid, pv_m);
`else
      check("product", product, acc_m % MOD2N);
      check("prod_valid", prod_valid, 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  int k_seen;
  int pv_seen;

  // Drive one cycle of strobes, then return just after the following negedge.
  task automatic step(input logic l, input logic a, input logic s);
    load = l; ad = a; sh = s;
    @(negedge clk); #1;
    if (prod_valid) pv_seen++;
    load = 1'b0; ad = 1'b0; sh = 1'b0;
  endtask

  task automatic do_load(input int a, input int b);
    mcand = N'(a); mplier = N'(b);
    step(1'b1, 1'b0, 1'b0);
    check("k_after_load", k, 0);
  endtask

  // Alternate add and shift cycles, as the control FSM does. ad follows m.
  task automatic run_op(input int a, input int b, input string tag);
    logic [N-1:0] bv;
    bv = N'(b);
    do_load(a, b);
    k_seen = 0; pv_seen = 0;
    for (int i = 0; i < N; i++) begin
      check({tag, "_m_add"}, m, bv[i]);
      step(1'b0, m, 1'b0);
      if (k) k_seen++;
      step(1'b0, 1'b0, 1'b1);
    end
    check({tag, "_product"}, product, a * b);
    check({tag, "_k_once"}, k_seen, 1);
`ifdef PROD_REG_EN
    check({tag, "_pv_once"}, pv_seen, 1);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    check("rst_m", m, 0);
    check("rst_k", k, 0);
    check("rst_product", product, 0);
    check("rst_pv", prod_valid, 0);
    chk_en = 1'b1;

    // Test 1: 13 x 11.
    run_op(13, 11, "t1");
    // Test 2: 15 x 15. The carry into ACC[2N] is exercised mid-operation.
    run_op(15, 15, "t2");
    // Test 3: zero operands.
    run_op(0, 9, "t3a");
    run_op(9, 0, "t3b");

    // Test 4: assert reset after two shifts; all registers clear.
    do_load(13, 11);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, m, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("t4_rst_product", product, 0);
    check("t4_rst_k", k, 0);
    check("t4_rst_m", m, 0);
    run_op(7, 6, "t4");

    // Test 5: reload mid-operation; no residue from the aborted operation.
    do_load(13, 11);
    step(1'b0, m, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, m, 1'b0);
    run_op(5, 3, "t5");

    // Test 6: combined add+shift cycles (ad=m, sh=1). The product is ready
    // after N cycles and the counter wraps back to 0.
    do_load(13, 11);
    k_seen = 0; pv_seen = 0;
    for (int i = 0; i < N; i++) begin
      if (k) k_seen++;
      step(1'b0, m, 1'b1);
    end
    check("t6_product", product, 143);
    check("t6_k_once", k_seen, 1);
    check("t6_cnt_wrap_k", k, 0);
`ifdef PROD_REG_EN
    check("t6_pv_once", pv_seen, 1);
    // Load does not clear the registered product.
    do_load(2, 3);
    check("t6_hold_after_load", product, 143);
`endif

    step(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
